bus_hold_arb: RTL and testbench

Bus-side responder for the `hold` / `vramcs` DMA request protocol that the video unit and future DMA masters initiate. It halts the 6800-style CPU and waits for bus-available, then hands the shared memory bus to the DMA master and returns it cleanly afterwards. It sits between the CPU core, the DMA master and the external RAM, and exports sticky error and usage counters for firmware diagnostics.

---
 rtl/bus_hold_arb_if.sv | 45 ++++
 rtl/bus_hold_arb.sv | 131 +++++++++++++
 tb/tb_bus_hold_arb.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bus_hold_arb_if.sv
// CPU, DMA master and RAM bus bundle seen by the hold/vramcs arbiter.
// slave = arbiter side, master = the surrounding system (CPU core, DMA master, RAM, firmware).
interface bus_hold_arb_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      cpu_addr;
  logic [7:0]       cpu_dout;
  logic             cpu_rw;
  logic             cpu_vma;
  logic             cpu_ba;
  logic             cpu_halt;
  logic [7:0]       cpu_din;
  logic             dma_hold;
  logic             dma_cs;
  logic [15:0]      dma_addr;
  logic             dma_grant;
  logic [7:0]       dma_data;
  logic [15:0]      mem_addr;
  logic [7:0]       mem_dout;
  logic [7:0]       mem_din;
  logic             mem_cs;
  logic             mem_we;
  logic             clr_stat;
  logic             late_err;
  logic [7:0]       late_cnt;
  logic [CNT_W-1:0] grant_cnt;

  modport slave (
    input  cpu_addr, cpu_dout, cpu_rw, cpu_vma, cpu_ba,
    input  dma_hold, dma_cs, dma_addr,
    input  mem_din, clr_stat,
    output cpu_halt, cpu_din, dma_grant, dma_data,
    output mem_addr, mem_dout, mem_cs, mem_we,
    output late_err, late_cnt, grant_cnt
  );

  modport master (
    output cpu_addr, cpu_dout, cpu_rw, cpu_vma, cpu_ba,
    output dma_hold, dma_cs, dma_addr,
    output mem_din, clr_stat,
    input  cpu_halt, cpu_din, dma_grant, dma_data,
    input  mem_addr, mem_dout, mem_cs, mem_we,
    input  late_err, late_cnt, grant_cnt
  );
endinterface

// File: rtl/bus_hold_arb.sv
// Halts the CPU on a DMA hold request, hands the RAM bus to the DMA master once the CPU
// reports bus-available (or after TIMEOUT cycles), and returns it through one turnaround cycle.
module bus_hold_arb #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input logic          clk,
  input logic          rst,
  bus_hold_arb_if.slave bus
);
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state;
  logic             halt;
  logic             grant;
  logic [WAIT_W-1:0] wait_cnt;
  logic             late_err;
  logic [7:0]       late_cnt;
  logic [CNT_W-1:0] grant_cnt;
  logic             late_evt;
  logic             grant_evt;

  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_cs;
  logic        mem_we;

  // A forced grant: CPU never raised bus-available within the wait window.
  assign late_evt  = (state == REQ) && bus.dma_hold && !bus.cpu_ba && (wait_cnt == WAIT_LAST);
  assign grant_evt = (state == GRANT) && bus.dma_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      halt     <= 1'b0;
      grant    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dma_hold) begin
            state    <= REQ;
            halt     <= 1'b1;
            wait_cnt <= '0;
          end
        end
        REQ: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (!bus.dma_hold) begin
            state <= RELEASE;
          end else if (bus.cpu_ba || (wait_cnt == WAIT_LAST)) begin
            state <= GRANT;
            grant <= 1'b1;
          end
        end
        GRANT: begin
          if (!bus.dma_hold) begin
            state <= RELEASE;
            grant <= 1'b0;
          end
        end
        RELEASE: begin
          state <= IDLE;
          halt  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          halt  <= 1'b0;
          grant <= 1'b0;
        end
      endcase
    end
  end

  // Clear wins over any same-cycle set or increment.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_stat) begin
      late_err  <= 1'b0;
      late_cnt  <= 8'd0;
      grant_cnt <= '0;
    end else begin
      if (late_evt) begin
        late_err <= 1'b1;
        if (late_cnt != 8'hFF) late_cnt <= late_cnt + 8'd1;
      end
      if (grant_evt && (grant_cnt != {CNT_W{1'b1}})) grant_cnt <= grant_cnt + 1'b1;
    end
  end

  // RELEASE parks the bus idle so a pending CPU write cannot slip through during turnaround.
  always_comb begin
    mem_addr = bus.cpu_addr;
    mem_dout = bus.cpu_dout;
    mem_cs   = bus.cpu_vma;
    mem_we   = bus.cpu_vma & ~bus.cpu_rw;
    case (state)
      GRANT: begin
        mem_addr = bus.dma_addr;
        mem_dout = 8'd0;
        mem_cs   = bus.dma_cs;
        mem_we   = 1'b0;
      end
      RELEASE: begin
        mem_dout = 8'd0;
        mem_cs   = 1'b0;
        mem_we   = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr  = mem_addr;
  assign bus.mem_dout  = mem_dout;
  assign bus.mem_cs    = mem_cs;
  assign bus.mem_we    = mem_we;
  assign bus.cpu_halt  = halt;
  assign bus.dma_grant = grant;
  assign bus.cpu_din   = bus.mem_din;
  assign bus.dma_data  = bus.mem_din;
  assign bus.late_err  = late_err;
  assign bus.late_cnt  = late_cnt;
  assign bus.grant_cnt = grant_cnt;
endmodule

// File: tb/tb_bus_hold_arb.sv
// Directed bench for bus_hold_arb: expectations queued on drive, popped and asserted on sample.
module tb_bus_hold_arb;
  localparam int TIMEOUT  = 16;
  localparam int CNT_W    = 16;
  localparam int HOLD_LEN = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bus_hold_arb_if #(.CNT_W(CNT_W)) bus ();

  bus_hold_arb #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Number of rising edges from now until dma_grant is seen high, -1 if it never comes.
  task automatic wait_grant(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.dma_grant) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;

    rst          = 1'b1;
    bus.cpu_addr = 16'h0000;
    bus.cpu_dout = 8'h00;
    bus.cpu_rw   = 1'b1;
    bus.cpu_vma  = 1'b0;
    bus.cpu_ba   = 1'b0;
    bus.dma_hold = 1'b0;
    bus.dma_cs   = 1'b0;
    bus.dma_addr = 16'h0000;
    bus.mem_din  = 8'h00;
    bus.clr_stat = 1'b0;

    // Reset
    repeat (2) @(negedge clk);
    expect_val("rst_halt", 0);      check(bus.cpu_halt);
    expect_val("rst_grant", 0);     check(bus.dma_grant);
    expect_val("rst_mem_cs", 0);    check(bus.mem_cs);
    expect_val("rst_mem_we", 0);    check(bus.mem_we);
    expect_val("rst_late_err", 0);  check(bus.late_err);
    expect_val("rst_late_cnt", 0);  check(bus.late_cnt);
    expect_val("rst_grant_cnt", 0); check(bus.grant_cnt);

    rst          = 1'b0;
    bus.cpu_vma  = 1'b1;
    bus.cpu_rw   = 1'b0;
    bus.cpu_addr = 16'h1234;
    bus.cpu_dout = 8'h5A;
    bus.mem_din  = 8'h3C;
    @(negedge clk);
    expect_val("idle_mem_we", 1);        check(bus.mem_we);
    expect_val("idle_mem_addr", 16'h1234); check(bus.mem_addr);
    expect_val("idle_mem_dout", 8'h5A);  check(bus.mem_dout);
    expect_val("idle_cpu_din", 8'h3C);   check(bus.cpu_din);

    // Fast grant
    bus.cpu_vma  = 1'b0;
    bus.cpu_rw   = 1'b1;
    bus.cpu_ba   = 1'b1;
    bus.dma_addr = 16'h8000;
    bus.dma_cs   = 1'b1;
    bus.mem_din  = 8'hA5;
    bus.dma_hold = 1'b1;
    expect_val("fast_latency", 2);
    wait_grant(n);
    check(n);
    expect_val("fast_mem_addr", 16'h8000); check(bus.mem_addr);
    expect_val("fast_mem_we", 0);          check(bus.mem_we);
    expect_val("fast_mem_cs", 1);          check(bus.mem_cs);
    expect_val("fast_dma_data", 8'hA5);    check(bus.dma_data);
    expect_val("fast_halt", 1);            check(bus.cpu_halt);
    repeat (HOLD_LEN - 2) @(negedge clk);
    bus.dma_hold = 1'b0;
    // Grant cycles with the hold still asserted: entry edge and REQ edge excluded.
    expect_val("fast_grant_cnt", HOLD_LEN - 2);
    check(bus.grant_cnt);
    @(negedge clk);
    expect_val("rel_halt", 1);  check(bus.cpu_halt);
    expect_val("rel_grant", 0); check(bus.dma_grant);
    @(negedge clk);
    expect_val("rel_idle_halt", 0); check(bus.cpu_halt);

    // Timeout
    bus.cpu_ba   = 1'b0;
    bus.dma_hold = 1'b1;
    expect_val("timeout_latency", TIMEOUT + 1);
    wait_grant(n);
    check(n);
    expect_val("timeout_late_err", 1); check(bus.late_err);
    expect_val("timeout_late_cnt", 1); check(bus.late_cnt);
    bus.dma_hold = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 299; i++) begin
      bus.dma_hold = 1'b1;
      wait_grant(n);
      bus.dma_hold = 1'b0;
      repeat (2) @(negedge clk);
    end
    expect_val("late_cnt_sat", 255); check(bus.late_cnt);
    expect_val("late_err_sticky", 1); check(bus.late_err);

    // Write blocking
    bus.cpu_ba   = 1'b1;
    bus.dma_hold = 1'b1;
    wait_grant(n);
    bus.cpu_vma  = 1'b1;
    bus.cpu_rw   = 1'b0;
    bus.cpu_addr = 16'h4000;
    #1;
    expect_val("wblk_grant_we", 0); check(bus.mem_we);
    expect_val("wblk_grant_addr", 16'h8000); check(bus.mem_addr);
    bus.dma_hold = 1'b0;
    @(negedge clk);
    expect_val("wblk_rel_we", 0); check(bus.mem_we);
    expect_val("wblk_rel_cs", 0); check(bus.mem_cs);
    @(negedge clk);
    expect_val("wblk_idle_we", 1); check(bus.mem_we);

    // Clear priority
    bus.dma_hold = 1'b1;
    wait_grant(n);
    @(negedge clk);
    bus.clr_stat = 1'b1;
    @(negedge clk);
    expect_val("clr_grant_cnt", 0); check(bus.grant_cnt);
    expect_val("clr_late_cnt", 0);  check(bus.late_cnt);
    expect_val("clr_late_err", 0);  check(bus.late_err);
    bus.clr_stat = 1'b0;
    @(negedge clk);
    expect_val("clr_then_count", 1); check(bus.grant_cnt);

    // Mid-grant reset
    rst = 1'b1;
    @(negedge clk);
    expect_val("mrst_grant", 0);          check(bus.dma_grant);
    expect_val("mrst_halt", 0);           check(bus.cpu_halt);
    expect_val("mrst_mem_addr", 16'h4000); check(bus.mem_addr);
    rst          = 1'b0;
    bus.dma_hold = 1'b0;
    @(negedge clk);
    expect_val("mrst_idle_halt", 0); check(bus.cpu_halt);

    if (sb_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
